// File: rtl/intersection_phase_scheduler.sv
// Two-road phase sequencer: NS/EW green-yellow-allred with ped walk.
// Ports: clk, rst(async low), car_ew, ped_req -> ns/ew_lights, walk, ped_ack.
module intersection_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       walk,
  output logic       ped_ack
);

  localparam int M1 = (GREEN_MIN > GREEN_MAX) ? GREEN_MIN : GREEN_MAX;
  localparam int M2 = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int MP = (M3 > WALK_T) ? M3 : WALK_T;
  localparam int CW = $clog2(MP) + 1;

  localparam logic [CW-1:0] GMIN_E = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_E = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_E  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_E   = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] WLK_E  = CW'(WALK_T - 1);
  localparam logic [CW-1:0] CMAX   = '1;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  typedef enum logic [1:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_ALLRED,
    PH_WALK
  } phase_t;

  phase_t        phase, phase_nx;
  logic          dir, dir_nx;
  logic          ped_pend, pend_nx;
  logic          adv;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= PH_GREEN;
      dir      <= 1'b0;
      ped_pend <= 1'b0;
      cnt      <= '0;
    end else begin
      phase    <= phase_nx;
      dir      <= dir_nx;
      ped_pend <= pend_nx;
      if (adv)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    phase_nx = phase;
    dir_nx   = dir;
    adv      = 1'b0;
    unique case (phase)
      PH_GREEN: begin
        if (!dir)
          adv = (cnt >= GMIN_E) && (car_ew || ped_pend);
        else
          adv = (cnt == GMAX_E) ||
                ((cnt >= GMIN_E) && (!car_ew || ped_pend));
        if (adv)
          phase_nx = PH_YELLOW;
      end
      PH_YELLOW: begin
        adv = (cnt == YEL_E);
        if (adv)
          phase_nx = PH_ALLRED;
      end
      PH_ALLRED: begin
        adv = (cnt == AR_E);
        if (adv && ped_pend) begin
          phase_nx = PH_WALK;
        end else if (adv) begin
          phase_nx = PH_GREEN;
          dir_nx   = ~dir;
        end
      end
      PH_WALK: begin
        adv = (cnt == WLK_E);
        if (adv) begin
          phase_nx = PH_GREEN;
          dir_nx   = ~dir;
        end
      end
      default: begin
        phase_nx = PH_GREEN;
        adv      = 1'b1;
      end
    endcase
  end

  // Clearing on WALK entry wins over a same-cycle request.
  always_comb begin
    pend_nx = ped_pend;
    if (ped_req && (phase != PH_WALK))
      pend_nx = 1'b1;
    if (phase_nx == PH_WALK && phase != PH_WALK)
      pend_nx = 1'b0;
  end

  always_comb begin
    ns_lights = L_RED;
    ew_lights = L_RED;
    walk      = 1'b0;
    ped_ack   = 1'b0;
    unique case (phase)
      PH_GREEN: begin
        if (dir) ew_lights = L_GRN;
        else     ns_lights = L_GRN;
      end
      PH_YELLOW: begin
        if (dir) ew_lights = L_YEL;
        else     ns_lights = L_YEL;
      end
      PH_ALLRED: ;
      PH_WALK: begin
        walk    = 1'b1;
        ped_ack = (cnt == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler.
// Expected lamp sequences are queued from phase durations, popped per cycle.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       car_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_lights, ew_lights;
  logic       walk, ped_ack;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];

  // {ns, ew, walk, ped_ack}
  localparam logic [7:0] NSG = {3'b001, 3'b100, 1'b0, 1'b0};
  localparam logic [7:0] NSY = {3'b010, 3'b100, 1'b0, 1'b0};
  localparam logic [7:0] EWG = {3'b100, 3'b001, 1'b0, 1'b0};
  localparam logic [7:0] EWY = {3'b100, 3'b010, 1'b0, 1'b0};
  localparam logic [7:0] AR  = {3'b100, 3'b100, 1'b0, 1'b0};
  localparam logic [7:0] WK  = {3'b100, 3'b100, 1'b1, 1'b0};
  localparam logic [7:0] WKA = {3'b100, 3'b100, 1'b1, 1'b1};

  intersection_phase_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .car_ew    (car_ew),
    .ped_req   (ped_req),
    .ns_lights (ns_lights),
    .ew_lights (ew_lights),
    .walk      (walk),
    .ped_ack   (ped_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got %b exp %b", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(v);
  endtask

  task automatic sample(input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    got = {ns_lights, ew_lights, walk, ped_ack};
    if (exp_q.size() == 0) begin
      chk({tag, "_underflow"}, 8'd1, 8'd0);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, got, exp);
    end
    chk("inv", {7'd0, $onehot(ns_lights) && $onehot(ew_lights) &&
               (ns_lights == 3'b100 || ew_lights == 3'b100) &&
               (!ped_ack || walk)}, 8'd1);
  endtask

  // One clock cycle: drive at negedge, sample 1ns later.
  task automatic step(input string tag, input logic car, input logic ped);
    @(negedge clk);
    rst     = 1'b1;
    car_ew  = car;
    ped_req = ped;
    #1;
    sample(tag);
  endtask

  task automatic hold_reset();
    rst     = 1'b0;
    car_ew  = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    // 1: idle, NS green forever
    hold_reset();
    #1;
    chk("rst", {ns_lights, ew_lights, walk, ped_ack}, NSG);
    push(NSG, 50);
    for (int c = 0; c < 50; c++)
      step("idle", 1'b0, 1'b0);

    // 2: continuous car_ew, 18-cycle period
    hold_reset();
    for (int p = 0; p < 2; p++) begin
      push(NSG, 4); push(NSY, 2); push(AR, 1);
      push(EWG, 8); push(EWY, 2); push(AR, 1);
    end
    push(NSG, 2);
    for (int c = 0; c < 38; c++)
      step("cont", 1'b1, 1'b0);

    // 3: single car pulse at cycle 10
    hold_reset();
    push(NSG, 11); push(NSY, 2); push(AR, 1);
    push(EWG, 4); push(EWY, 2); push(AR, 1);
    push(NSG, 6);
    for (int c = 0; c < 27; c++)
      step("pulse", c == 10, 1'b0);

    // 4: ped call at 2, repeat call inside WALK ignored
    hold_reset();
    push(NSG, 4); push(NSY, 2); push(AR, 1);
    push(WKA, 1); push(WK, 2);
    push(EWG, 4); push(EWY, 2); push(AR, 1);
    push(NSG, 14);
    for (int c = 0; c < 31; c++)
      step("ped", 1'b0, (c == 2) || (c == 8));

    // 5: async reset mid EW yellow with a pending call
    hold_reset();
    push(NSG, 4); push(NSY, 2); push(AR, 1);
    push(EWG, 7); push(EWY, 1);
    for (int c = 0; c < 15; c++)
      step("pre", 1'b1, c == 12);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", {ns_lights, ew_lights, walk, ped_ack}, NSG);
    repeat (2) @(posedge clk);
    push(NSG, 20);
    for (int c = 0; c < 20; c++)
      step("post", 1'b0, 1'b0);

    chk("q_empty", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 1 exp 0");
    $fatal(1);
  end

endmodule
